// File: rtl/pipeline_uart_fifo.sv
// UART transceiver for the MEM-stage peripheral bus: baud tick generator,
// oversampled 8N1 receiver with start-bit glitch filter, transmitter, and
// TX/RX FIFOs with occupancy counts and sticky RX error flags.

// Circular FIFO, first-word-fall-through read port, 0 on the head when empty.
module pipeline_uart_fifo_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  // a push against a full FIFO is still taken when the same cycle pops
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

  // pointer update; wrap is the natural overflow of the extra MSB
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // storage needs no reset; the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wr_data;
  end
endmodule

module pipeline_uart_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tx_wr_en,
  input  logic [7:0]               tx_wr_data,
  output logic                     tx_full,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   tx_count,
  input  logic                     rx_rd_en,
  output logic [7:0]               rx_rd_data,
  output logic                     rx_empty,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     rx_overrun,
  output logic                     rx_frame_err,
  input  logic                     err_clr,
  input  logic                     uart_rx,
  output logic                     uart_tx
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);

  generate
    if (DIV < 1) begin : g_bad_div
      $error("pipeline_uart_fifo: CLK_FREQ too low for BAUD*OVERSAMPLE");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
      $error("pipeline_uart_fifo: OVERSAMPLE must be even and >= 4");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("pipeline_uart_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- baud tick ----------------
  logic [DW-1:0] baud_cnt;
  logic          tick;
  assign tick = (baud_cnt == DIV_LAST);

  // free-running divider, one-clk tick at DIV-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + DW'(1);
  end

  // ---------------- FIFOs ----------------
  logic       tx_pop, tx_empty;
  logic [7:0] tx_head;
  logic       rx_push, rx_full;
  logic [7:0] rx_sh, rx_sh_nxt;

  pipeline_uart_fifo_buf #(.DEPTH(DEPTH), .W(8)) u_tx_fifo (
    .clk(clk), .reset(reset),
    .wr_en(tx_wr_en), .wr_data(tx_wr_data),
    .rd_en(tx_pop), .rd_data(tx_head),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  pipeline_uart_fifo_buf #(.DEPTH(DEPTH), .W(8)) u_rx_fifo (
    .clk(clk), .reset(reset),
    .wr_en(rx_push), .wr_data(rx_sh),
    .rd_en(rx_rd_en), .rd_data(rx_rd_data),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // ---------------- TX ----------------
  state_t         tx_state, tx_state_nxt;
  logic [OSW-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]     tx_bit, tx_bit_nxt;
  logic [7:0]     tx_sh, tx_sh_nxt;
  logic           tx_q, tx_q_nxt;

  assign uart_tx = tx_q;
  assign tx_busy = (tx_state != S_IDLE);

  // TX registers; uart_tx is registered so it is glitch-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_sh    <= tx_sh_nxt;
      tx_q     <= tx_q_nxt;
    end
  end

  // TX next state: each bit spans OVERSAMPLE ticks; frames chain from STOP
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_sh_nxt    = tx_sh;
    tx_q_nxt     = tx_q;
    tx_pop       = 1'b0;
    case (tx_state)
      S_IDLE: if (tick && !tx_empty) begin
        tx_pop       = 1'b1;
        tx_sh_nxt    = tx_head;
        tx_q_nxt     = 1'b0;
        tx_cnt_nxt   = '0;
        tx_state_nxt = S_START;
      end
      S_START: if (tick) begin
        if (tx_cnt == OS_LAST) begin
          tx_cnt_nxt   = '0;
          tx_bit_nxt   = '0;
          tx_q_nxt     = tx_sh[0];
          tx_state_nxt = S_DATA;
        end else tx_cnt_nxt = tx_cnt + OSW'(1);
      end
      S_DATA: if (tick) begin
        if (tx_cnt == OS_LAST) begin
          tx_cnt_nxt = '0;
          if (tx_bit == 3'd7) begin
            tx_q_nxt     = 1'b1;
            tx_state_nxt = S_STOP;
          end else begin
            tx_bit_nxt = tx_bit + 3'd1;
            tx_sh_nxt  = {1'b0, tx_sh[7:1]};
            tx_q_nxt   = tx_sh[1];
          end
        end else tx_cnt_nxt = tx_cnt + OSW'(1);
      end
      S_STOP: if (tick) begin
        if (tx_cnt == OS_LAST) begin
          tx_cnt_nxt = '0;
          if (!tx_empty) begin
            tx_pop       = 1'b1;
            tx_sh_nxt    = tx_head;
            tx_q_nxt     = 1'b0;
            tx_state_nxt = S_START;
          end else tx_state_nxt = S_IDLE;
        end else tx_cnt_nxt = tx_cnt + OSW'(1);
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- RX ----------------
  logic [1:0]     rx_sync;
  logic           rx_s, rx_prev, rx_fall;
  state_t         rx_state, rx_state_nxt;
  logic [OSW-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]     rx_bit, rx_bit_nxt;
  logic           set_ovr, set_fe;

  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_prev && !rx_s;

  // 2-flop synchroniser plus edge-detect history, idle-high at reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
    end
  end

  // RX registers and sticky error flags (a new error beats err_clr)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_sh    <= rx_sh_nxt;
      if (set_ovr)      rx_overrun <= 1'b1;
      else if (err_clr) rx_overrun <= 1'b0;
      if (set_fe)       rx_frame_err <= 1'b1;
      else if (err_clr) rx_frame_err <= 1'b0;
    end
  end

  // RX next state: mid-bit sampling; only a clean stop bit pushes a byte
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_sh_nxt    = rx_sh;
    rx_push      = 1'b0;
    set_ovr      = 1'b0;
    set_fe       = 1'b0;
    case (rx_state)
      S_IDLE: if (rx_fall) begin
        rx_cnt_nxt   = '0;
        rx_state_nxt = S_START;
      end
      S_START: if (tick) begin
        if (rx_cnt == OS_HALF) begin
          rx_cnt_nxt = '0;
          rx_bit_nxt = '0;
          // line back high by mid start bit: glitch, not a frame
          rx_state_nxt = rx_s ? S_IDLE : S_DATA;
        end else rx_cnt_nxt = rx_cnt + OSW'(1);
      end
      S_DATA: if (tick) begin
        if (rx_cnt == OS_LAST) begin
          rx_cnt_nxt = '0;
          rx_sh_nxt  = {rx_s, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state_nxt = S_STOP;
          else                rx_bit_nxt   = rx_bit + 3'd1;
        end else rx_cnt_nxt = rx_cnt + OSW'(1);
      end
      S_STOP: if (tick) begin
        if (rx_cnt == OS_LAST) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = S_IDLE;
          if (!rx_s)        set_fe  = 1'b1;
          else if (rx_full) set_ovr = 1'b1;
          else              rx_push = 1'b1;
        end else rx_cnt_nxt = rx_cnt + OSW'(1);
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end
endmodule
